// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite types, response codes, FSM encodings and strobe merge
//
// Contents:
//   resp_t / RESP_OKAY / RESP_SLVERR : response encodings
//   strb_t                           : fixed 32-bit-bus strobe type kept for older users
//   w_state_t / r_state_t            : write and read FSM state encodings
//   strb_merge()                     : byte-lane merge of a new word over an old one (up to 64 bits)
package axi_lite_pkg;

   typedef logic [1:0] resp_t;
   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;

   // Older 32-bit-only blocks size their strobes with this; the parametrised bank does not.
   typedef logic [3:0] strb_t;

   typedef logic [1:0] w_state_t;
   localparam w_state_t W_IDLE   = 2'd0;
   localparam w_state_t W_HAVE_A = 2'd1;
   localparam w_state_t W_HAVE_D = 2'd2;
   localparam w_state_t W_RESP   = 2'd3;

   typedef logic [0:0] r_state_t;
   localparam r_state_t R_IDLE = 1'b0;
   localparam r_state_t R_RESP = 1'b1;

   // Sized for the widest supported bus; narrower callers zero-extend and truncate.
   function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                              input logic [63:0] new_word,
                                              input logic [7:0]  strb);
      logic [63:0] merged;
      for (int b = 0; b < 8; b++) begin
         merged[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axi_lite_addr_dec.sv
// rtl/axi_lite_addr_dec.sv - combinational register index / in-range decode
//
// Ports:
//   addr     in  ADDR_W  byte address from AW or AR channel
//   idx      out IDX_W   register index (addr[ADDR_LSB +: IDX_W])
//   in_range out 1       word address (all bits above ADDR_LSB) below NUM_REGS
module axi_lite_addr_dec #(
   parameter int ADDR_W   = 8,
   parameter int ADDR_LSB = 2,
   parameter int IDX_W    = 2,
   parameter int NUM_REGS = 4
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [IDX_W-1:0]  idx,
   output logic              in_range
);

   logic [31:0] word_addr;

   // Byte-offset bits within a word carry no meaning for register selection.
   wire unused_lsb = &{1'b0, addr[ADDR_LSB-1:0]};

   assign word_addr = 32'(addr[ADDR_W-1:ADDR_LSB]);
   assign in_range  = (word_addr < 32'(NUM_REGS));
   assign idx       = addr[ADDR_LSB +: IDX_W];

endmodule

// File: rtl/axi_lite_regs.sv
// rtl/axi_lite_regs.sv - parametrised AXI4-Lite slave register bank
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   awaddr/awvalid/awready             write address channel
//   wdata/wstrb/wvalid/wready          write data channel
//   bresp/bvalid/bready                write response channel
//   araddr/arvalid/arready             read address channel
//   rdata/rresp/rvalid/rready          read data channel
//   reg_o                              flat register contents, reg i at [i*DATA_W +: DATA_W]
//   wr_pulse_o                         one-cycle pulse per register after an in-range write
// Build option: AXIL_REGS_WSTRB_EN enables per-byte write strobes; otherwise full-word writes.
module axi_lite_regs
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [ADDR_W-1:0]            awaddr,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [DATA_W/8-1:0]          wstrb,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   input  logic [ADDR_W-1:0]            araddr,
   input  logic                         arvalid,
   output logic                         arready,
   output logic [DATA_W-1:0]            rdata,
   output logic [1:0]                   rresp,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [NUM_REGS*DATA_W-1:0]   reg_o,
   output logic [NUM_REGS-1:0]          wr_pulse_o
);

   localparam int ADDR_LSB = (DATA_W == 64) ? 3 : 2;
   localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int STRB_W   = DATA_W / 8;

   logic [DATA_W-1:0] regs [NUM_REGS];

   logic [IDX_W-1:0]  aw_idx, ar_idx, aw_idx_q, c_idx;
   logic              aw_ok, ar_ok, aw_ok_q, c_ok;
   logic [DATA_W-1:0] wdata_q, c_data, rd_word;
   logic [STRB_W-1:0] wstrb_q, c_strb;
   w_state_t          wstate, wnext;
   r_state_t          rstate, rnext;
   logic              aw_hs, w_hs, ar_hs, commit;

   axi_lite_addr_dec #(.ADDR_W(ADDR_W), .ADDR_LSB(ADDR_LSB), .IDX_W(IDX_W), .NUM_REGS(NUM_REGS))
      u_aw_dec (.addr(awaddr), .idx(aw_idx), .in_range(aw_ok));

   axi_lite_addr_dec #(.ADDR_W(ADDR_W), .ADDR_LSB(ADDR_LSB), .IDX_W(IDX_W), .NUM_REGS(NUM_REGS))
      u_ar_dec (.addr(araddr), .idx(ar_idx), .in_range(ar_ok));

`ifdef AXIL_REGS_WSTRB_EN
   function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [STRB_W-1:0] strb);
      logic [63:0] m;
      m = strb_merge(64'(old_word), 64'(new_word), 8'(strb));
      return m[DATA_W-1:0];
   endfunction
`else
   wire unused_strb = &{1'b0, c_strb};
`endif

   assign aw_hs  = awvalid & awready;
   assign w_hs   = wvalid & wready;
   assign ar_hs  = arvalid & arready;
   assign bvalid = (wstate == W_RESP);
   assign rvalid = (rstate == R_RESP);

   // Whichever half arrived first was captured; the other comes straight off the bus.
   assign c_idx  = (wstate == W_HAVE_A) ? aw_idx_q : aw_idx;
   assign c_ok   = (wstate == W_HAVE_A) ? aw_ok_q  : aw_ok;
   assign c_data = (wstate == W_HAVE_D) ? wdata_q  : wdata;
   assign c_strb = (wstate == W_HAVE_D) ? wstrb_q  : wstrb;

   always_comb begin
      wnext  = wstate;
      commit = 1'b0;
      case (wstate)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wnext  = W_RESP;
               commit = 1'b1;
            end else if (aw_hs) begin
               wnext = W_HAVE_A;
            end else if (w_hs) begin
               wnext = W_HAVE_D;
            end
         end
         W_HAVE_A: if (w_hs) begin
            wnext  = W_RESP;
            commit = 1'b1;
         end
         W_HAVE_D: if (aw_hs) begin
            wnext  = W_RESP;
            commit = 1'b1;
         end
         default: if (bvalid && bready) wnext = W_IDLE;
      endcase
   end

   // Readys are flops so they read 0 throughout reset and rise on the first edge after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wstate     <= W_IDLE;
         awready    <= 1'b0;
         wready     <= 1'b0;
         bresp      <= RESP_OKAY;
         wr_pulse_o <= '0;
         aw_idx_q   <= '0;
         aw_ok_q    <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         wstate     <= wnext;
         awready    <= (wnext == W_IDLE) || (wnext == W_HAVE_D);
         wready     <= (wnext == W_IDLE) || (wnext == W_HAVE_A);
         wr_pulse_o <= '0;
         if (aw_hs) begin
            aw_idx_q <= aw_idx;
            aw_ok_q  <= aw_ok;
         end
         if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end
         if (commit) begin
            bresp <= c_ok ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (c_ok && (c_idx == IDX_W'(i))) begin
`ifdef AXIL_REGS_WSTRB_EN
                  regs[i] <= merge_word(regs[i], c_data, c_strb);
`else
                  regs[i] <= c_data;
`endif
                  wr_pulse_o[i] <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      rnext = rstate;
      if (rstate == R_IDLE) begin
         if (ar_hs) rnext = R_RESP;
      end else if (rvalid && rready) begin
         rnext = R_IDLE;
      end
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ar_ok && (ar_idx == IDX_W'(i))) rd_word = regs[i];
      end
   end

   // rd_word samples regs before this edge's write lands, so a colliding read sees the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rstate  <= R_IDLE;
         arready <= 1'b0;
         rdata   <= '0;
         rresp   <= RESP_OKAY;
      end else begin
         rstate  <= rnext;
         arready <= (rnext == R_IDLE);
         if (ar_hs) begin
            rdata <= rd_word;
            rresp <= ar_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   always_comb begin
      reg_o = '0;
      for (int i = 0; i < NUM_REGS; i++) reg_o[i*DATA_W +: DATA_W] = regs[i];
   end

endmodule

// File: doc/axi_lite_regs.md
# axi_lite_regs

Parametrised AXI4-Lite slave register bank: a generalised successor to the fixed 32-bit AXI-Lite bus definition, with configurable address/data width and register count. Accepts write address and write data independently and in any order, answers reads with registered data, and flags out-of-range accesses with SLVERR. Sits behind the SoC AXI-Lite interconnect and exposes its registers flat to peripheral fabric (UART, timers, GPIO control).

## Interface
- ADDR_W, 8: AXI address width in bits.
- DATA_W, 32: data width in bits; must be 32 or 64.
- NUM_REGS, 4: number of registers; 1 to 2^(ADDR_W-ADDR_LSB).
- Derived: ADDR_LSB = log2(DATA_W/8); IDX_W = max(1, clog2(NUM_REGS)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- awaddr  in  ADDR_W  write address.
- awvalid / awready  in / out  1  write-address handshake.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte strobes.
- wvalid / wready  in / out  1  write-data handshake.
- bresp  out  2  write response.
- bvalid / bready  out / in  1  write-response handshake.
- araddr  in  ADDR_W  read address.
- arvalid / arready  in / out  1  read-address handshake.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response.
- rvalid / rready  out / in  1  read-data handshake.
- reg_o  out  NUM_REGS*DATA_W  register contents; register i at [i*DATA_W +: DATA_W].
- wr_pulse_o  out  NUM_REGS  one-cycle pulse in the cycle after register i is written.

## Operation
- Decode: idx = addr[ADDR_LSB +: IDX_W]. Access is in range iff every bit of addr above ADDR_LSB, read as an integer, is < NUM_REGS. Low ADDR_LSB bits are ignored.
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
  - W_HAVE_A: address captured; awready=0, wready=1.
  - W_HAVE_D: data and strobe captured; awready=1, wready=0.
  - W_RESP: awready=0, wready=0, bvalid=1.
- Write transitions: the second of the AW/W pair to handshake, or both in the same cycle, commits the write at that edge and moves to W_RESP. W_RESP -> W_IDLE on bvalid && bready.
- Write commit, in range: register updated, wr_pulse_o[idx]=1 for one cycle, bresp=OKAY.
- Write commit, out of range: no register change, no pulse, bresp=SLVERR.
- Read FSM states:
  - R_IDLE: arready=1. On handshake: rdata/rresp registered, move to R_RESP.
  - R_RESP: arready=0, rvalid=1; rdata/rresp held stable until rvalid && rready, then R_IDLE.
- Read, out of range: rdata=0, rresp=SLVERR.
- Read and write paths are fully independent.
- Read handshake in the same edge as a write commit to the same register returns the old value.

## Timing
- Reset (asynchronous, rst_n low):
  - all registers 0; FSMs to IDLE.
  - bvalid=0, rvalid=0, bresp=OKAY, rresp=OKAY, rdata=0, wr_pulse_o=0.
  - awready, wready and arready are registered: 0 while reset is asserted, 1 from the first clk edge after rst_n deasserts.
- Write latency: commit at the handshake edge; bvalid and wr_pulse_o high in the following cycle. Back-to-back writes: one per 2 cycles with bready tied high.
- Read latency: rvalid high in the cycle after the AR handshake. Back-to-back reads: one per 2 cycles.
- Backpressure: bvalid/rvalid and their payloads held indefinitely while ready is low; no new transaction is accepted on that channel meanwhile.
- Reset asserted mid-transaction aborts it: pending response dropped, partial AW/W capture discarded.

## Configuration
- AXIL_REGS_WSTRB_EN defined: byte lane b is written only when wstrb[b]=1. wstrb=0 still produces an OKAY response and a pulse.
- AXIL_REGS_WSTRB_EN undefined: wstrb is ignored and every in-range write updates the full word.

## Structure
- axi_lite_pkg gains:
  - resp_t encodings as named constants: OKAY=2'b00, SLVERR=2'b10.
  - FSM state enums for the write and read paths.
  - a strobe-merge function (old, new, strb) -> merged word.
- The existing fixed 32-bit strb_t is kept for legacy users; this block sizes strobes from DATA_W.
- One natural sub-module, axi_lite_addr_dec: combinational idx/in-range decode, instantiated twice (AW and AR).

## Test plan
- AW+W same cycle: awaddr=0x04, wdata=0xDEADBEEF, wstrb=0xF -> bvalid next cycle, bresp=OKAY, wr_pulse_o=4'b0010. Read 0x04 -> rdata=0xDEADBEEF, rresp=OKAY, reg_o[63:32]=0xDEADBEEF.
- W 3 cycles before AW (addr 0x08, data 0x11) -> wready=0 after W capture; commit on AW handshake; exactly one bresp; reg 2=0x11.
- Out of range, addr 0x10 with NUM_REGS=4 -> write gives SLVERR, no reg change, no pulse; read gives SLVERR, rdata=0.
- bready held 0 for 5 cycles -> bvalid=1 and bresp stable throughout, awready=wready=0; next write accepted after the release cycle.
- Strobes: reg=0xDEADBEEF, write 0x12345678 with wstrb=0x3 -> 0xDEAD5678 with macro defined, 0x12345678 without.
- rst_n pulsed low while rvalid=1 and reg 1=0xDEADBEEF -> rvalid=0 immediately, reg_o all 0, readys 0 until the first edge after release.
